// File: rtl/fabric_pkg.sv
// Shared fabric definitions for the connection blocks:
// state enum, default geometry and config-bit index helper.
package fabric_pkg;

  localparam int DEF_W        = 7;
  localparam int DEF_LOGICOUT = 2;

  typedef enum logic [1:0] {
    UNCONFIG = 2'd0,
    SHIFTING = 2'd1,
    ACTIVE   = 2'd2
  } cb_state_t;

  // Config bit linking logic output i to track j.
  function automatic int cfg_idx(
    input int j,
    input int i,
    input int w
  );
    return j + i * w;
  endfunction

endpackage

// File: rtl/config_shift_chain.sv
// Serial configuration shift chain with a saturating shift counter.
// Ports: clk, reset, cfg_en, cfg_in -> c[N-1:0], cfg_out (=c[0]), cnt.
module config_shift_chain
  import fabric_pkg::*;
#(
  parameter int N = DEF_W * DEF_LOGICOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_en,
  input  logic                   cfg_in,
  output logic [N-1:0]           c,
  output logic                   cfg_out,
  output logic [$clog2(N+1)-1:0] cnt
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  always_ff @(posedge clk) begin
    if (reset) begin
      c   <= '0;
      cnt <= '0;
    end else if (cfg_en) begin
      c   <= {cfg_in, c[N-1:1]};
      cnt <= (cnt == N_CNT) ? N_CNT : cnt + CW'(1);
    end else if (cnt == N_CNT) begin
      // A completed load seen with cfg_en low hands over to the
      // block; rearm so the next load counts from 1 again.
      cnt <= '0;
    end
  end

  assign cfg_out = c[0];

endmodule

// File: rtl/output_connection_block.sv
// Drives logic-block outputs onto routing tracks per a serial config.
// Ports: clk, reset, logic_output, track (inout), cfg_en, cfg_in,
//   cfg_out, cfg_done, conflict.
// Option: OUTPUT_CONNECTION_BLOCK_REG_EN registers logic_output
//   before the track drivers (one cycle of latency).
module output_connection_block
  import fabric_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int LOGICOUT = DEF_LOGICOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LOGICOUT-1:0] logic_output,
  inout  wire  [W-1:0]        track,
  input  logic                cfg_en,
  input  logic                cfg_in,
  output logic                cfg_out,
  output logic                cfg_done,
  output logic                conflict
);

  localparam int N  = W * LOGICOUT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [N-1:0]        c;
  logic [CW-1:0]       cnt;
  cb_state_t           state;
  logic [LOGICOUT-1:0] src;
  logic [W-1:0]        drive_en;
  logic [W-1:0]        drive_val;
  logic [W-1:0]        multi;
  logic [W-1:0]        oe;
  logic                load_done;
  logic                stay_active;
  logic                act_next;

  config_shift_chain #(
    .N(N)
  ) u_chain (
    .clk    (clk),
    .reset  (reset),
    .cfg_en (cfg_en),
    .cfg_in (cfg_in),
    .c      (c),
    .cfg_out(cfg_out),
    .cnt    (cnt)
  );

`ifdef OUTPUT_CONNECTION_BLOCK_REG_EN
  logic [LOGICOUT-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (reset) lo_q <= '0;
    else       lo_q <= logic_output;
  end

  assign src = lo_q;
`else
  assign src = logic_output;
`endif

  // Per-track priority mux: lowest enabled output index wins,
  // any further enabled source marks the track as contended.
  always_comb begin
    drive_en  = '0;
    drive_val = '0;
    multi     = '0;
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < LOGICOUT; i++) begin
        if (c[cfg_idx(j, i, W)]) begin
          if (drive_en[j]) begin
            multi[j] = 1'b1;
          end else begin
            drive_en[j]  = 1'b1;
            drive_val[j] = src[i];
          end
        end
      end
    end
  end

  assign load_done = (state == SHIFTING) && !cfg_en
                   && (cnt == N_CNT);
  assign stay_active = (state == ACTIVE) && !cfg_en;
  assign act_next = load_done || stay_active;

  // Chain contents are frozen in ACTIVE, so conflict can be
  // registered alongside the state with no input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNCONFIG;
      cfg_done <= 1'b0;
      conflict <= 1'b0;
    end else begin
      unique case (state)
        UNCONFIG: if (cfg_en) state <= SHIFTING;
        SHIFTING: if (load_done) state <= ACTIVE;
        ACTIVE:   if (cfg_en) state <= SHIFTING;
        default:  state <= UNCONFIG;
      endcase
      cfg_done <= act_next;
      conflict <= act_next && (|multi);
    end
  end

  assign oe = drive_en & {W{state == ACTIVE}};

  for (genvar j = 0; j < W; j++) begin : g_drv
    assign track[j] = oe[j] ? drive_val[j] : 1'bz;
  end

endmodule

// File: tb/tb_output_connection_block.sv
// Self-checking bench for output_connection_block: vector table,
// directed corner sequences and randomized runs vs a reference model.
module tb_output_connection_block;

  localparam int W  = 7;
  localparam int LO = 2;
  localparam int N  = W * LO;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en;
  logic        cfg_in;
  logic [1:0]  logic_output;
  wire  [6:0]  track;
  logic        cfg_out;
  logic        cfg_done;
  logic        conflict;

  int n_chk  = 0;
  int n_fail = 0;

  // Released tracks read back as 1.
  for (genvar k = 0; k < W; k++) begin : g_pu
    pullup (track[k]);
  end

  always #5 clk = ~clk;

  output_connection_block dut (
    .clk         (clk),
    .reset       (reset),
    .logic_output(logic_output),
    .track       (track),
    .cfg_en      (cfg_en),
    .cfg_in      (cfg_in),
    .cfg_out     (cfg_out),
    .cfg_done    (cfg_done),
    .conflict    (conflict)
  );

  // Reference model: history of shifted bits, plain flags.
  bit       hist[$];
  bit       m_active;
  bit       m_shifting;
  int       m_shifts;
  bit [1:0] m_lo_q;

  function automatic bit mc(int k);
    int idx;
    idx = hist.size() - N + k;
    return (idx >= 0) ? hist[idx] : 1'b0;
  endfunction

  function automatic logic [6:0] exp_track();
    logic [6:0] r;
    logic [1:0] s;
`ifdef OUTPUT_CONNECTION_BLOCK_REG_EN
    s = m_lo_q;
`else
    s = logic_output;
`endif
    r = 7'h7f;
    if (m_active) begin
      for (int j = 0; j < W; j++) begin
        for (int i = LO - 1; i >= 0; i--) begin
          if (mc(j + i * W)) r[j] = s[i];
        end
      end
    end
    return r;
  endfunction

  function automatic bit exp_conflict();
    int n;
    if (!m_active) return 1'b0;
    for (int j = 0; j < W; j++) begin
      n = 0;
      for (int i = 0; i < LO; i++) n += int'(mc(j + i * W));
      if (n >= 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(bit rst, bit en, bit din);
    if (rst) begin
      hist.delete();
      m_active   = 0;
      m_shifting = 0;
      m_shifts   = 0;
      m_lo_q     = 0;
    end else begin
      m_lo_q = logic_output;
      if (en) begin
        hist.push_back(din);
        if (hist.size() > N) void'(hist.pop_front());
        m_shifts   = m_shifting ? m_shifts + 1 : 1;
        m_shifting = 1;
        m_active   = 0;
      end else if (m_shifting && m_shifts >= N) begin
        m_shifting = 0;
        m_active   = 1;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    chk({nm, ".done"}, 32'(cfg_done), 32'(m_active));
    chk({nm, ".conflict"}, 32'(conflict), 32'(exp_conflict()));
    chk({nm, ".cfg_out"}, 32'(cfg_out), 32'(mc(0)));
    chk({nm, ".track"}, 32'(track), 32'(exp_track()));
  endtask

  task automatic cyc(bit rst, bit en, bit din);
    reset  = rst;
    cfg_en = en;
    cfg_in = din;
    @(posedge clk);
    model_edge(rst, en, din);
    #1;
    check_all("cyc");
  endtask

  task automatic load(logic [13:0] v);
    for (int k = 0; k < N; k++) cyc(0, 1, v[k]);
    cyc(0, 0, 0);
  endtask

  typedef struct {
    logic [13:0] cfg;
    logic [1:0]  lo;
    logic [6:0]  trk;
    logic        cfl;
  } vec_t;

  vec_t vt[9];
  bit   sent[$];

  initial begin
    vt[0] = '{14'h0008, 2'b01, 7'h7f, 1'b0};
    vt[1] = '{14'h0008, 2'b00, 7'h77, 1'b0};
    vt[2] = '{14'h0008, 2'b10, 7'h77, 1'b0};
    vt[3] = '{14'h0204, 2'b10, 7'h7b, 1'b1};
    vt[4] = '{14'h0204, 2'b01, 7'h7f, 1'b1};
    vt[5] = '{14'h2000, 2'b01, 7'h3f, 1'b0};
    vt[6] = '{14'h3fff, 2'b10, 7'h00, 1'b1};
    vt[7] = '{14'h3f80, 2'b10, 7'h7f, 1'b0};
    vt[8] = '{14'h3f80, 2'b01, 7'h00, 1'b0};

    logic_output = 2'b00;
    reset  = 1'b1;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst.done", 32'(cfg_done), 0);
    chk("rst.conflict", 32'(conflict), 0);
    chk("rst.cfg_out", 32'(cfg_out), 0);
    chk("rst.track", 32'(track), 32'h7f);

    // Reset in the middle of a load, then a clean reload.
    for (int k = 0; k < 5; k++) cyc(0, 1, 1);
    cfg_en = 1'b1;
    cyc(1, 1, 1);
    chk("midrst.done", 32'(cfg_done), 0);
    chk("midrst.track", 32'(track), 32'h7f);
    chk("midrst.cfg_out", 32'(cfg_out), 0);
    load(14'h0008);
    chk("reload.done", 32'(cfg_done), 1);

    // Vector table.
    foreach (vt[t]) begin
      logic_output = 2'b00;
      load(vt[t].cfg);
      logic_output = vt[t].lo;
      cyc(0, 0, 0);
      chk($sformatf("vec%0d.track", t), 32'(track),
          32'(vt[t].trk));
      chk($sformatf("vec%0d.conflict", t), 32'(conflict),
          32'(vt[t].cfl));
      chk($sformatf("vec%0d.done", t), 32'(cfg_done), 1);
    end

    // Single route: track 3 follows output 0.
    logic_output = 2'b00;
    load(14'h0008);
    logic_output = 2'b01;
    cyc(0, 0, 0);
    chk("route.hi", 32'(track), 32'h7f);
    logic_output = 2'b00;
    #1;
`ifndef OUTPUT_CONNECTION_BLOCK_REG_EN
    chk("route.comb", 32'(track), 32'h77);
`endif
    cyc(0, 0, 0);
    chk("route.lo", 32'(track), 32'h77);
    chk("route.conflict", 32'(conflict), 0);

    // Leaving ACTIVE drops cfg_done and releases tracks at once.
    cyc(0, 1, 0);
    chk("leave.done", 32'(cfg_done), 0);
    chk("leave.track", 32'(track), 32'h7f);

    // Pause then over-shift.
    cyc(1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0);
      chk("pause.done", 32'(cfg_done), 0);
      chk("pause.track", 32'(track), 32'h7f);
    end
    for (int k = 0; k < 10; k++) cyc(0, 1, 0);
    chk("over.done0", 32'(cfg_done), 0);
    cyc(0, 0, 0);
    chk("over.done", 32'(cfg_done), 1);
    logic_output = 2'b00;
    cyc(0, 0, 0);
    chk("over.track", 32'(track), 32'h70);

    // Chain pass-through.
    cyc(1, 0, 0);
    sent.delete();
    for (int s = 1; s <= 2 * N; s++) begin
      sent.push_back(1'($urandom));
      cyc(0, 1, sent[s-1]);
      if (s >= N)
        chk($sformatf("pass%0d", s), 32'(cfg_out),
            32'(sent[s-N]));
    end

    // Randomized load / run phases.
    for (int p = 0; p < 30; p++) begin
      int nsh;
      if ($urandom_range(0, 7) == 0) cyc(1, 0, 0);
      nsh = $urandom_range(10, 20);
      while (nsh > 0) begin
        bit en;
        en = ($urandom_range(0, 3) != 0);
        logic_output = 2'($urandom);
        cyc(0, en, ($urandom_range(0, 2) == 0));
        if (en) nsh--;
      end
      for (int k = 0; k < $urandom_range(2, 6); k++) begin
        logic_output = 2'($urandom);
        cyc(0, 0, 0);
        logic_output = 2'($urandom);
        #1;
        check_all("rand.mid");
      end
    end

`ifdef OUTPUT_CONNECTION_BLOCK_REG_EN
    // Registered drive: one clock of latency.
    logic_output = 2'b00;
    load(14'h2000);
    cyc(0, 0, 0);
    chk("reg.pre", 32'(track), 32'h3f);
    logic_output = 2'b10;
    #1;
    chk("reg.hold", 32'(track), 32'h3f);
    cyc(0, 0, 0);
    chk("reg.rise", 32'(track), 32'h7f);
`else
    logic_output = 2'b00;
    load(14'h2000);
    chk("comb.pre", 32'(track), 32'h3f);
    logic_output = 2'b10;
    #1;
    chk("comb.rise", 32'(track), 32'h7f);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/output_connection_block.md
# output_connection_block

Drives logic-block outputs onto routing tracks; the transmit-side counterpart of the control connection block, which selects tracks into logic-block inputs. Holds its own W*LOGICOUT configuration bits in a serial shift chain loaded through the fabric's configuration path. Sits beside each logic tile and feeds the same track bundle the control connection block reads.

## Interface
- W, 7, number of routing tracks.
- LOGICOUT, 2, number of logic-block outputs.
- Derived N = W*LOGICOUT: configuration chain length.

Ports:
- clk  in  1  fabric clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- logic_output  in  LOGICOUT  logic-block output values.
- track  inout  W  routing tracks; bit j is driven or released (z) per configuration.
- cfg_en  in  1  shift enable for the configuration chain.
- cfg_in  in  1  serial configuration data in.
- cfg_out  out  1  serial data out = cfg bit 0, for daisy-chaining the next block.
- cfg_done  out  1  high in ACTIVE state.
- conflict  out  1  high in ACTIVE when any track has more than one enabled source.

## Operation
- Config bit c[j+i*W] = 1 connects logic_output[i] to track[j].
- Shift: when cfg_en=1, c <= {cfg_in, c[N-1:1]}. First bit shifted in reaches index 0 after N shifts. cfg_out = c[0].
- Shift counter cnt, range 0..N, saturating at N.
- States:
  - UNCONFIG (reset state): tracks all z. cfg_en=1 -> SHIFTING, cnt <= 1.
  - SHIFTING: each cfg_en=1 cycle shifts and increments cnt (saturating). cfg_en=0 with cnt<N: stay (paused, chain contents held). cfg_en=0 with cnt==N: -> ACTIVE.
  - ACTIVE: track[j] driven when any c[j+i*W]=1; value = logic_output[i] for the lowest such i; otherwise z. cfg_en=1 -> SHIFTING, cnt <= 1, with a shift that same cycle.
- Tracks are z in UNCONFIG and SHIFTING (no contention while the chain is in flux).
- Shifts beyond N are legal: the last N bits shifted in win.
- conflict = ACTIVE and, for any j, two or more i with c[j+i*W]=1. Lowest-index priority still applies.

## Timing
- Reset values: c=0, cnt=0, state=UNCONFIG, cfg_out=0, cfg_done=0, conflict=0, track all z.
- Reset takes priority over cfg_en in the same cycle. Reset during SHIFTING or ACTIVE clears everything and releases tracks on the next edge.
- cfg_done and conflict are decoded from registered state; no combinational path from inputs.
- cfg_out changes one cycle after each shift edge. Chain in-to-out latency is N shifts.
- cfg_done rises on the edge after the first cfg_en=0 cycle with cnt==N. It falls on the edge where cfg_en=1 is sampled in ACTIVE.
- Track drive in ACTIVE is combinational from logic_output, zero latency (default build).

## Configuration
- OUTPUT_CONNECTION_BLOCK_REG_EN:
  - Defined: logic_output is captured in a LOGICOUT-bit register (reset 0) every cycle, and tracks are driven from the register. This adds 1 cycle of latency.
  - Undefined: the drive path is purely combinational.
- Config chain, state machine and conflict logic are identical in both builds.

## Structure
- Shared package `fabric_pkg`: state enum (UNCONFIG, SHIFTING, ACTIVE), cfg index helper (j + i*W), default W and LOGICOUT constants. The same package is used by the control connection block.
- One sub-module: `config_shift_chain` (parameter N; ports clk, reset, cfg_en, cfg_in, c[N-1:0], cfg_out, cnt), reusable by the control connection block.
- Top level holds the FSM, per-track priority mux and tristate drivers.

## Test plan
- Reset mid-shift: after 5 shifts, assert reset for 1 cycle -> cfg_done=0, track=7'bzzzzzzz, cfg_out=0, and a fresh 14-shift load works.
- Single route: shift in c with only c[3]=1 (logic_output[0] to track[3]), then cfg_en=0 -> cfg_done=1 next edge. Toggle logic_output[0] -> track[3] follows; all other tracks z; conflict=0.
- Conflict: set c[2] and c[2+7]; logic_output=2'b10 -> track[2]=0 (index 0 wins), conflict=1.
- Pause and over-shift: shift 6 bits, hold cfg_en=0 for 3 cycles -> still SHIFTING, tracks z. Then shift 10 more -> the last 14 bits are loaded, and cfg_done rises after cfg_en drops.
- Chain pass-through: 28 random bits on cfg_in -> cfg_out reproduces bits 0..13 delayed by 14 shifts.
- With OUTPUT_CONNECTION_BLOCK_REG_EN defined: route output 1 to track 6, step logic_output[1] 0->1 -> track[6] rises exactly one clk later.
